reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter: AWIDTH, default 32, width of the register address on all ports.
REQ-002 Parameter: DWIDTH, default 32, width of the register data on all ports.
REQ-003 Parameter: RD_LATENCY, default 2, legal range 0..15; cycles from the get_stb cycle to the cycle in which get_data is valid.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) has a pending transaction.
REQ-007 reqN_ready  out  1  requester N transaction accepted this cycle.
REQ-008 reqN_wr  in  1  1=write (set), 0=read (get).
REQ-009 reqN_addr  in  AWIDTH  register address.
REQ-010 reqN_wdata  in  DWIDTH  write data; ignored for reads.
REQ-011 rspN_valid  out  1  one-cycle completion pulse to requester N.
REQ-012 rspN_rdata  out  DWIDTH  read data; valid while rspN_valid=1 for reads, holds last value otherwise.
REQ-013 set_addr, set_data  out  AWIDTH, DWIDTH  shared settings-bus write address and data (registered).
REQ-014 set_stb  out  1  one-cycle settings-bus write strobe.
REQ-015 get_addr  out  AWIDTH  shared readback address (registered).
REQ-016 get_stb  out  1  one-cycle readback strobe.
REQ-017 get_data  in  DWIDTH  readback data from the register space.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 grant  out  1  index of the requester owning the current or most recent transaction.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, RESP; there is at most one outstanding transaction.
REQ-021 IDLE: reqN_ready SHALL be asserted combinationally for exactly one requester with reqN_valid=1, chosen by arbitration; other states: both reqN_ready=0.
REQ-022 Arbitration SHALL be round-robin: if only one requester is valid it wins; if both are valid, the requester not equal to grant wins.
REQ-023 On acceptance (cycle T) the FSM SHALL latch wr, addr and wdata into set_addr/set_data (write) or get_addr (read), update grant, and enter ISSUE.
REQ-024 ISSUE (cycle T+1): set_stb=1 for a write, or get_stb=1 for a read; exactly one strobe, exactly one cycle.
REQ-025 Write: ISSUE -> RESP; rspN_valid=1 in cycle T+2; RESP -> IDLE; next acceptance possible in cycle T+3.
REQ-026 Read with RD_LATENCY=0: get_data SHALL be captured at the end of the ISSUE cycle; ISSUE -> RESP.
REQ-027 Read with RD_LATENCY>0: ISSUE -> WAIT; WAIT lasts RD_LATENCY cycles (4-bit down-counter); get_data captured at end of the last WAIT cycle (cycle T+1+RD_LATENCY); then RESP.
REQ-028 Read response: rspN_valid=1 for one cycle in cycle T+2+RD_LATENCY, rspN_rdata=captured get_data.
REQ-029 Only the rsp port matching grant SHALL pulse; the other rspN_valid remains 0 and its rspN_rdata is unchanged.
REQ-030 Responses SHALL have no back-pressure; requesters must accept the pulse.
REQ-031 set_addr, set_data, get_addr SHALL hold their values between transactions; a read SHALL NOT change set_addr/set_data and a write SHALL NOT change get_addr.
REQ-032 Requester inputs changing outside IDLE SHALL have no effect on the transaction in progress.
REQ-033 A requester that deasserts reqN_valid before acceptance SHALL simply not be served (no partial transaction).

Reset
REQ-034 While rst=1, immediately and regardless of clk: state=IDLE, counter=0, grant=1 (so requester 0 wins first tie), all strobes, reqN_ready-driving state, rspN_valid and busy =0, set_addr/set_data/get_addr/rspN_rdata=0.
REQ-035 Reset asserted mid-transaction SHALL abort it: no strobe and no response pulse are issued for it after reset release.

Verification
REQ-036 Single write: req0 wr addr=0x10 wdata=0xCAFE0001 at T -> set_addr=0x10, set_data=0xCAFE0001, set_stb at T+1 only, rsp0_valid at T+2, busy T+1..T+2.
REQ-037 Single read, RD_LATENCY=2: req1 read addr=0x24, get_data=0x12345678 in T+3 -> get_stb at T+1, rsp1_valid at T+4 with rsp1_rdata=0x12345678, rsp0_valid stays 0.
REQ-038 Contention: both requesters valid continuously after reset -> grants alternate 0,1,0,1; each strobe corresponds to the granted requester's addr/data; no starvation over 8 transactions.
REQ-039 RD_LATENCY=0 build: read with get_data=0xA5A5A5A5 combinational from get_addr -> rsp valid at T+2 with 0xA5A5A5A5.
REQ-040 Reset in WAIT cycle: read accepted, rst pulsed at T+2 -> no rsp pulse, all outputs 0, next request accepted normally with requester 0 winning a tie.
REQ-041 Inputs toggled during busy (addr/wdata/wr changed at T+1) -> issued strobe and bus values reflect the values latched at T.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter onto a shared settings/readback register bus.
// One transaction in flight at a time: IDLE -> ISSUE -> [WAIT] -> RESP.
module reg_bus_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DWIDTH-1:0] rsp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DWIDTH-1:0] rsp1_rdata,

  output logic [AWIDTH-1:0] set_addr,
  output logic [DWIDTH-1:0] set_data,
  output logic              set_stb,
  output logic [AWIDTH-1:0] get_addr,
  output logic              get_stb,
  input  logic [DWIDTH-1:0] get_data,

  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam bit       HAS_WAIT  = (RD_LATENCY != 0);
  localparam logic [3:0] WAIT_LOAD = 4'(RD_LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              cur_wr;
  logic              req_any, req_sel, accept, capture;
  logic              acc_wr;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_wdata;

  always_comb begin
    req_any    = req0_valid | req1_valid;
    // On a tie the requester that did not own the last transaction wins.
    req_sel    = (req0_valid & req1_valid) ? ~grant : req1_valid;
    accept     = (state == IDLE) & req_any;
    req0_ready = accept & ~req_sel;
    req1_ready = accept & req_sel;
    acc_wr     = req_sel ? req1_wr    : req0_wr;
    acc_addr   = req_sel ? req1_addr  : req0_addr;
    acc_wdata  = req_sel ? req1_wdata : req0_wdata;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (cur_wr) begin
          state_nxt = RESP;
        end else if (HAS_WAIT) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = RESP;
          capture   = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    set_stb    = (state == ISSUE) &  cur_wr;
    get_stb    = (state == ISSUE) & ~cur_wr;
    rsp0_valid = (state == RESP)  & ~grant;
    rsp1_valid = (state == RESP)  &  grant;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      grant      <= 1'b1;
      cur_wr     <= 1'b0;
      set_addr   <= '0;
      set_data   <= '0;
      get_addr   <= '0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      if (accept) begin
        grant  <= req_sel;
        cur_wr <= acc_wr;
        if (acc_wr) begin
          set_addr <= acc_addr;
          set_data <= acc_wdata;
        end else begin
          get_addr <= acc_addr;
        end
      end
      if (HAS_WAIT && state == ISSUE && !cur_wr) cnt <= WAIT_LOAD;
      else if (state == WAIT && cnt != 4'd0)     cnt <= cnt - 4'd1;
      // Capture lands on the edge entering RESP, so rdata changes with the pulse.
      if (capture) begin
        if (grant) rsp1_rdata <= get_data;
        else       rsp0_rdata <= get_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Random two-requester traffic on an RD_LATENCY=2 and an RD_LATENCY=0 instance,
// compared each cycle against a transaction-timeline reference model.
module tb_reg_bus_arbiter;

  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v     [2][2];
  logic        wr    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        rdy   [2][2];
  logic        rv    [2][2];
  logic [31:0] rd    [2][2];
  logic [31:0] sa [2], sd [2], ga [2], gd [2];
  logic        ss [2], gs [2], bz [2], gr [2];

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] c);
    return (a * 32'h9E37_79B1) ^ c ^ 32'h5A5A_A5A5;
  endfunction

  assign gd[0] = mix(ga[0], 32'(cyc));
  assign gd[1] = mix(ga[1], 32'(cyc));

  reg_bus_arbiter #(.AWIDTH(32), .DWIDTH(32), .RD_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .req0_valid(v[0][0]), .req0_ready(rdy[0][0]), .req0_wr(wr[0][0]),
    .req0_addr(addr[0][0]), .req0_wdata(wdata[0][0]),
    .rsp0_valid(rv[0][0]), .rsp0_rdata(rd[0][0]),
    .req1_valid(v[0][1]), .req1_ready(rdy[0][1]), .req1_wr(wr[0][1]),
    .req1_addr(addr[0][1]), .req1_wdata(wdata[0][1]),
    .rsp1_valid(rv[0][1]), .rsp1_rdata(rd[0][1]),
    .set_addr(sa[0]), .set_data(sd[0]), .set_stb(ss[0]),
    .get_addr(ga[0]), .get_stb(gs[0]), .get_data(gd[0]),
    .busy(bz[0]), .grant(gr[0])
  );

  reg_bus_arbiter #(.AWIDTH(32), .DWIDTH(32), .RD_LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst),
    .req0_valid(v[1][0]), .req0_ready(rdy[1][0]), .req0_wr(wr[1][0]),
    .req0_addr(addr[1][0]), .req0_wdata(wdata[1][0]),
    .rsp0_valid(rv[1][0]), .rsp0_rdata(rd[1][0]),
    .req1_valid(v[1][1]), .req1_ready(rdy[1][1]), .req1_wr(wr[1][1]),
    .req1_addr(addr[1][1]), .req1_wdata(wdata[1][1]),
    .rsp1_valid(rv[1][1]), .rsp1_rdata(rd[1][1]),
    .set_addr(sa[1]), .set_data(sd[1]), .set_stb(ss[1]),
    .get_addr(ga[1]), .get_stb(gs[1]), .get_data(gd[1]),
    .busy(bz[1]), .grant(gr[1])
  );

  // Reference model: each accepted transaction is a set of absolute cycle numbers.
  int          free_at [2];
  int          stb_c   [2];
  int          cap_c   [2];
  int          rsp_c   [2];
  bit          m_grant [2];
  bit          m_wr    [2];
  logic [31:0] m_sa [2], m_sd [2], m_ga [2];
  logic [31:0] held [2][2];
  bit          acc  [2][2];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit pick(input bit v0, input bit v1, input bit g);
    return (v0 && v1) ? !g : v1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      free_at[d] = 0;
      stb_c[d]   = -1;
      cap_c[d]   = -1;
      rsp_c[d]   = -1;
      m_grant[d] = 1'b1;
      m_wr[d]    = 1'b0;
      m_sa[d]    = '0;
      m_sd[d]    = '0;
      m_ga[d]    = '0;
      for (int n = 0; n < 2; n++) begin
        held[d][n] = '0;
        acc[d][n]  = 1'b0;
        v[d][n]    = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (cyc == cap_c[d]) held[d][m_grant[d]] = mix(m_ga[d], 32'(cyc));
        if (cyc >= free_at[d] && (v[d][0] || v[d][1])) begin
          automatic int n = int'(pick(v[d][0], v[d][1], m_grant[d]));
          m_grant[d] = n[0];
          m_wr[d]    = wr[d][n];
          if (wr[d][n]) begin
            m_sa[d]  = addr[d][n];
            m_sd[d]  = wdata[d][n];
            cap_c[d] = -1;
            rsp_c[d] = cyc + 2;
          end else begin
            m_ga[d]  = addr[d][n];
            cap_c[d] = cyc + 1 + lat(d);
            rsp_c[d] = cyc + 2 + lat(d);
          end
          stb_c[d]   = cyc + 1;
          free_at[d] = rsp_c[d] + 1;
          acc[d][n]  = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit contend);
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        if (acc[d][n]) begin
          v[d][n]   = 1'b0;
          acc[d][n] = 1'b0;
        end
        if (v[d][n]) begin
          if (!contend && $urandom_range(0, 15) == 0) begin
            v[d][n] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            wr[d][n]    = 1'($urandom);
            addr[d][n]  = $urandom;
            wdata[d][n] = $urandom;
          end
        end else if (contend || $urandom_range(0, 2) == 0) begin
          v[d][n]     = 1'b1;
          wr[d][n]    = 1'($urandom);
          addr[d][n]  = $urandom;
          wdata[d][n] = $urandom;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      automatic bit idle = (cyc >= free_at[d]);
      automatic bit any  = v[d][0] || v[d][1];
      automatic bit win  = pick(v[d][0], v[d][1], m_grant[d]);
      check($sformatf("busy[d%0d]", d), 64'(bz[d]), 64'(!idle));
      check($sformatf("grant[d%0d]", d), 64'(gr[d]), 64'(m_grant[d]));
      check($sformatf("set_stb[d%0d]", d), 64'(ss[d]), 64'(cyc == stb_c[d] && m_wr[d]));
      check($sformatf("get_stb[d%0d]", d), 64'(gs[d]), 64'(cyc == stb_c[d] && !m_wr[d]));
      check($sformatf("set_addr[d%0d]", d), 64'(sa[d]), 64'(m_sa[d]));
      check($sformatf("set_data[d%0d]", d), 64'(sd[d]), 64'(m_sd[d]));
      check($sformatf("get_addr[d%0d]", d), 64'(ga[d]), 64'(m_ga[d]));
      for (int n = 0; n < 2; n++) begin
        check($sformatf("ready%0d[d%0d]", n, d), 64'(rdy[d][n]),
              64'(idle && any && int'(win) == n));
        check($sformatf("rsp%0d_valid[d%0d]", n, d), 64'(rv[d][n]),
              64'(cyc == rsp_c[d] && int'(m_grant[d]) == n));
        check($sformatf("rsp%0d_rdata[d%0d]", n, d), 64'(rd[d][n]), 64'(held[d][n]));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 2; n++) begin
        wr[d][n]    = 1'b0;
        addr[d][n]  = '0;
        wdata[d][n] = '0;
      end
    model_reset();
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rst = 1'b0;
        drive(cyc < 80);
      end else if (cyc > 100 &&
                   ($urandom_range(0, 59) == 0 ||
                    (cyc == stb_c[0] + 1 && !m_wr[0] && $urandom_range(0, 2) == 0))) begin
        // Abort whatever is in flight, including a read sitting in its first WAIT cycle.
        rst = 1'b1;
        model_reset();
      end else begin
        drive(cyc < 80);
      end
      #1;
      check_all();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
